// File: rtl/circle_test_pkg.sv
// Shared types and default geometry for the circle-test arbiter and its datapath.
// Derived widths: DW holds a signed coordinate delta, SQW a square, SUMW the sum of two squares.
package circle_test_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SUB  = 3'd1,
        SQX  = 3'd2,
        SQY  = 3'd3,
        CMP  = 3'd4,
        RESP = 3'd5
    } state_e;

    localparam int unsigned DEF_CW   = 32'd10;
    localparam int unsigned DEF_XC   = 32'd320;
    localparam int unsigned DEF_YC   = 32'd240;
    localparam int unsigned DEF_R2   = 32'd10000;
    localparam int unsigned DEF_DW   = DEF_CW + 32'd1;
    localparam int unsigned DEF_SQW  = 32'd2 * DEF_DW;
    localparam int unsigned DEF_SUMW = DEF_SQW + 32'd1;

endpackage

// File: rtl/circle_sq_dist.sv
// Squared-distance datapath: one shared multiplier squares dx then dy, and the
// sum of both squares is compared strictly against R2.
module circle_sq_dist
    import circle_test_pkg::*;
#(
    parameter int unsigned CW = DEF_CW,
    parameter int unsigned XC = DEF_XC,
    parameter int unsigned YC = DEF_YC,
    parameter int unsigned R2 = DEF_R2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_sub,
    input  logic          en_sqx,
    input  logic          en_sqy,
    input  logic          en_cmp,
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    output logic          in_circle
);

    localparam int unsigned DW   = CW + 32'd1;
    localparam int unsigned SQW  = 32'd2 * DW;
    localparam int unsigned SUMW = SQW + 32'd1;

    logic signed [DW-1:0]  dx_r;
    logic signed [DW-1:0]  dy_r;
    logic signed [DW-1:0]  mul_op_s;
    logic signed [SQW-1:0] mul_s;
    logic [SQW-1:0]        sq_r;
    logic [SQW-1:0]        acc_r;
    logic [SUMW-1:0]       sum_s;

    // Shared multiplier operand select and final sum of squares
    always_comb begin
        if (en_sqx) begin
            mul_op_s = dx_r;
        end else begin
            mul_op_s = dy_r;
        end
        mul_s = SQW'(mul_op_s) * SQW'(mul_op_s);
        sum_s = {1'b0, acc_r} + {1'b0, sq_r};
    end

    // Datapath registers, each loaded by its one-hot step enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dx_r      <= '0;
            dy_r      <= '0;
            sq_r      <= '0;
            acc_r     <= '0;
            in_circle <= 1'b0;
        end else begin
            if (en_sub) begin
                dx_r <= {1'b0, x} - DW'(XC);
                dy_r <= {1'b0, y} - DW'(YC);
            end
            if (en_sqx) begin
                sq_r <= $unsigned(mul_s);
            end
            // dx^2 moves to the accumulator while the multiplier is reused for dy^2
            if (en_sqy) begin
                acc_r <= sq_r;
                sq_r  <= $unsigned(mul_s);
            end
            if (en_cmp) begin
                in_circle <= (sum_s < SUMW'(R2));
            end
        end
    end

endmodule

// File: rtl/circle_test_arbiter.sv
// Round-robin arbiter and step sequencer sharing one circle-test datapath
// between two requesters; results return on a single tagged response channel.
module circle_test_arbiter
    import circle_test_pkg::*;
#(
    parameter int unsigned CW = DEF_CW,
    parameter int unsigned XC = DEF_XC,
    parameter int unsigned YC = DEF_YC,
    parameter int unsigned R2 = DEF_R2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req_valid,
    input  logic [CW-1:0] req_x0,
    input  logic [CW-1:0] req_y0,
    input  logic [CW-1:0] req_x1,
    input  logic [CW-1:0] req_y1,
    output logic [1:0]    req_ready,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic          rsp_in_circle,
    input  logic          rsp_ready,
    output logic          busy
);

    state_e        state_r;
    state_e        state_next_s;
    logic [1:0]    grant_s;
    logic          last_grant_r;
    logic [CW-1:0] x_r;
    logic [CW-1:0] y_r;
    logic          id_r;
    logic          rsp_id_r;
    logic          rsp_valid_r;
    logic          busy_r;

    // Grant and next-state; grants are suppressed while reset is asserted
    always_comb begin
        state_next_s = state_r;
        grant_s      = 2'b00;
        case (state_r)
            IDLE: begin
                if (reset) begin
                    case (req_valid)
                        2'b01:   grant_s = 2'b01;
                        2'b10:   grant_s = 2'b10;
                        2'b11:   grant_s = last_grant_r ? 2'b01 : 2'b10;
                        default: grant_s = 2'b00;
                    endcase
                end else begin
                    grant_s = 2'b00;
                end
                if (|grant_s) begin
                    state_next_s = SUB;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SUB:     state_next_s = SQX;
            SQX:     state_next_s = SQY;
            SQY:     state_next_s = CMP;
            CMP:     state_next_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register with registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            rsp_valid_r <= (state_next_s == RESP);
            busy_r      <= (state_next_s != IDLE);
        end
    end

    // Request capture on accept and response tag on compare
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_r <= 1'b1;
            x_r          <= '0;
            y_r          <= '0;
            id_r         <= 1'b0;
            rsp_id_r     <= 1'b0;
        end else begin
            if ((state_r == IDLE) && (|grant_s)) begin
                x_r          <= grant_s[1] ? req_x1 : req_x0;
                y_r          <= grant_s[1] ? req_y1 : req_y0;
                id_r         <= grant_s[1];
                last_grant_r <= grant_s[1];
            end
            if (state_r == CMP) begin
                rsp_id_r <= id_r;
            end
        end
    end

    circle_sq_dist #(
        .CW(CW),
        .XC(XC),
        .YC(YC),
        .R2(R2)
    ) u_sq_dist (
        .clk       (clk),
        .reset     (reset),
        .en_sub    (state_r == SUB),
        .en_sqx    (state_r == SQX),
        .en_sqy    (state_r == SQY),
        .en_cmp    (state_r == CMP),
        .x         (x_r),
        .y         (y_r),
        .in_circle (rsp_in_circle)
    );

    assign req_ready = grant_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_circle_test_arbiter.sv
// Directed and randomized checks of circle_test_arbiter against a behavioural
// model: distance arithmetic on ints and round-robin tracked by last served id.
module tb_circle_test_arbiter;

    localparam int CW = 10;
    localparam int XC = 320;
    localparam int YC = 240;
    localparam int R2 = 10000;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid;
    logic [CW-1:0] req_x0, req_y0, req_x1, req_y1;
    logic [1:0]    req_ready;
    logic          rsp_valid, rsp_id, rsp_in_circle, rsp_ready, busy;

    int checks = 0;
    int errors = 0;
    int last_id = 1;

    always #5 clk = ~clk;

    circle_test_arbiter #(.CW(CW), .XC(XC), .YC(YC), .R2(R2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_in_circle(rsp_in_circle), .rsp_ready(rsp_ready), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_in(input int x, input int y);
        int dx, dy;
        dx = x - XC;
        dy = y - YC;
        return (dx * dx + dy * dy) < R2;
    endfunction

    // One full request/response; called just after a clock edge with the DUT in IDLE
    task automatic transact(input logic [1:0] v, input int x0, input int y0,
                            input int x1, input int y1, input int hold, input string tag);
        int exp_id;
        bit exp_in;
        int n;
        req_valid = v;
        req_x0 = CW'(x0); req_y0 = CW'(y0);
        req_x1 = CW'(x1); req_y1 = CW'(y1);
        rsp_ready = (hold == 0);
        if (v == 2'b11) exp_id = (last_id == 1) ? 0 : 1;
        else            exp_id = v[1] ? 1 : 0;
        exp_in = (exp_id == 1) ? model_in(x1, y1) : model_in(x0, y0);
        #1;
        check({tag, ".ready"}, req_ready, (exp_id == 1) ? 2'b10 : 2'b01);
        @(posedge clk);
        last_id = exp_id;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            check({tag, ".busy"}, busy, 1'b1);
            check({tag, ".noready"}, req_ready, 2'b00);
            if (rsp_valid) break;
            @(posedge clk);
            n++;
        end
        check({tag, ".latency"}, n, 4);
        check({tag, ".id"}, rsp_id, exp_id);
        check({tag, ".in"}, rsp_in_circle, exp_in);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, ".hold_valid"}, rsp_valid, 1'b1);
            check({tag, ".hold_id"}, rsp_id, exp_id);
            check({tag, ".hold_in"}, rsp_in_circle, exp_in);
            check({tag, ".hold_busy"}, busy, 1'b1);
            check({tag, ".hold_ready"}, req_ready, 2'b00);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".done_valid"}, rsp_valid, 1'b0);
        check({tag, ".done_busy"}, busy, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 2'b00;
        req_x0 = '0; req_y0 = '0; req_x1 = '0; req_y1 = '0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.valid", rsp_valid, 1'b0);
        check("rst.id", rsp_id, 1'b0);
        check("rst.in", rsp_in_circle, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.ready", req_ready, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle.busy", busy, 1'b0);
        check("idle.ready", req_ready, 2'b00);
        last_id = 1;

        // Single request and circle boundaries
        transact(2'b01, 330, 250, 0, 0, 0, "t2");
        transact(2'b10, 0, 0, 420, 240, 0, "t3_edge");
        transact(2'b10, 0, 0, 419, 240, 0, "t3_inside");
        transact(2'b10, 0, 0, 0, 0, 0, "t3_origin");
        transact(2'b10, 0, 0, 1023, 1023, 0, "t3_max");

        // Fresh reset, then continuous contention must alternate 0,1,0,1
        reset = 1'b0;
        #2;
        reset = 1'b1;
        last_id = 1;
        transact(2'b11, 300, 200, 1000, 10, 0, "t4a");
        transact(2'b11, 300, 200, 1000, 10, 0, "t4b");
        transact(2'b11, 300, 200, 1000, 10, 0, "t4c");
        transact(2'b11, 300, 200, 1000, 10, 0, "t4d");

        // Back-pressure, then the pending request is taken in the first idle cycle
        transact(2'b11, 5, 5, 350, 260, 10, "t5a");
        transact(2'b11, 5, 5, 350, 260, 0, "t5b");

        // Request withdrawn before acceptance leaves no trace
        req_valid = 2'b10;
        #1;
        check("drop.ready", req_ready, 2'b10);
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        check("drop.busy", busy, 1'b0);
        check("drop.ready_after", req_ready, 2'b00);

        // Leave rsp_id=1, in_circle=1 so the mid-operation reset has something to clear
        transact(2'b10, 0, 0, 330, 250, 0, "t6pre");
        req_valid = 2'b01;
        req_x0 = CW'(330); req_y0 = CW'(250);
        #1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t6.valid", rsp_valid, 1'b0);
        check("t6.id", rsp_id, 1'b0);
        check("t6.in", rsp_in_circle, 1'b0);
        check("t6.busy", busy, 1'b0);
        check("t6.ready", req_ready, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t6.busy_held", busy, 1'b0);
        reset = 1'b1;
        last_id = 1;
        transact(2'b11, 330, 250, 1000, 1000, 0, "t6_tie");

        // Randomized traffic near and away from the circle
        for (int k = 0; k < 24; k++) begin
            int x0, y0, x1, y1;
            if (k % 2 == 0) begin
                x0 = XC - 110 + $urandom_range(0, 220);
                y0 = YC - 110 + $urandom_range(0, 220);
                x1 = XC - 110 + $urandom_range(0, 220);
                y1 = YC - 110 + $urandom_range(0, 220);
            end else begin
                x0 = $urandom_range(0, 1023);
                y0 = $urandom_range(0, 1023);
                x1 = $urandom_range(0, 1023);
                y1 = $urandom_range(0, 1023);
            end
            transact(2'($urandom_range(1, 3)), x0, y0, x1, y1, $urandom_range(0, 2), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
